// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, one full-subtractor cell, start/busy/done handshake
// Ports: clk, rst (async, active-high); start, a, b, bin sampled on the accepting edge;
//        busy (RUN), done (one-cycle pulse), diff = a - b - bin mod 2^WIDTH, bout = borrow-out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    // each new difference bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_one
            assign w_res_next = w_d;
        end else begin : g_many
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff    <= w_res_next;
                        bout    <= w_br_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor at WIDTH 8, 3 and 1
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic       s8, s3, s1, bi8, bi3, bi1;
    logic [7:0] a8, b8;
    logic [2:0] a3, b3;
    logic [0:0] a1, b1;
    logic       busy8, done8, bout8, busy3, done3, bout3, busy1, done1, bout1;
    logic [7:0] diff8;
    logic [2:0] diff3;
    logic [0:0] diff1;
    int         sel = 8;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       g_busy, g_done, g_bout;
    logic [7:0] g_diff;
    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .bin(bi3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3));
    serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bi1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
    assign g_busy = sel == 8 ? busy8 : sel == 3 ? busy3 : busy1;
    assign g_done = sel == 8 ? done8 : sel == 3 ? done3 : done1;
    assign g_bout = sel == 8 ? bout8 : sel == 3 ? bout3 : bout1;
    assign g_diff = sel == 8 ? diff8 : sel == 3 ? {5'b0, diff3} : {7'b0, diff1};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive(input int w, input int a, input int b, input int bin, input logic st);
        case (w)
            8: begin a8 = 8'(a); b8 = 8'(b); bi8 = 1'(bin); s8 = st; end
            3: begin a3 = 3'(a); b3 = 3'(b); bi3 = 1'(bin); s3 = st; end
            default: begin a1 = 1'(a); b1 = 1'(b); bi1 = 1'(bin); s1 = st; end
        endcase
    endtask
    task automatic wait_done(input int budget, output int k);
        k = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (g_done) begin
                k = i;
                break;
            end
        end
    endtask
    task automatic run_op(input int w, input int a, input int b, input int bin);
        int m, lat, busy_n, ed, eb;
        m  = 1 << w;
        ed = (a - b - bin + m) % m;
        eb = (a < b + bin) ? 1 : 0;
        sel = w;
        busy_n = 0;
        lat = 0;
        @(negedge clk);
        drive(w, a, b, bin, 1'b1);
        @(posedge clk);
        #1;
        drive(w, $urandom, $urandom, $urandom, 1'b0);
        for (int k = 1; k <= w + 3 && lat == 0; k++) begin
            if (g_busy) busy_n++;
            @(posedge clk);
            #1;
            if (g_done) lat = k;
        end
        chk($sformatf("lat w%0d %0h-%0h-%0h", w, a, b, bin), lat, w);
        chk($sformatf("busy_cycles w%0d %0h-%0h-%0h", w, a, b, bin), busy_n, w);
        chk($sformatf("diff w%0d %0h-%0h-%0h", w, a, b, bin), g_diff, ed);
        chk($sformatf("bout w%0d %0h-%0h-%0h", w, a, b, bin), g_bout, eb);
        chk($sformatf("busy_at_done w%0d", w), g_busy, 0);
        @(posedge clk);
        #1;
        chk($sformatf("done_pulse w%0d", w), g_done, 0);
    endtask
    initial begin
        int k, seen;
        rst = 1'b1;
        drive(8, 0, 0, 0, 1'b0);
        drive(3, 0, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset diff", diff8, 0);
        chk("reset bout", bout8, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8, 5, 3, 0);
        run_op(8, 3, 5, 0);
        run_op(8, 0, 0, 1);
        run_op(8, 'hFF, 'hFF, 1);
        run_op(8, 'h80, 'h01, 0);
        run_op(8, 3, 5, 0);
        sel = 8;
        @(negedge clk);
        drive(8, 'h55, 'h0F, 0, 1'b1);
        @(posedge clk);
        #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun rst busy", busy8, 0);
        chk("midrun rst done", done8, 0);
        chk("midrun rst diff", diff8, 0);
        chk("midrun rst bout", bout8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8) seen++;
        end
        chk("no done after rst", seen, 0);
        run_op(8, 'h55, 'h0F, 0);
        @(negedge clk);
        drive(8, 'h20, 'h01, 0, 1'b1);
        @(posedge clk);
        #1;
        s8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(8, 'h99, 'h11, 1, 1'b1);
        @(negedge clk);
        drive(8, 0, 0, 0, 1'b0);
        wait_done(10, k);
        chk("ignored start lat", k + 3, 8);
        chk("ignored start diff", diff8, 'h1F);
        chk("ignored start bout", bout8, 0);
        @(negedge clk);
        drive(8, 'h10, 'h04, 0, 1'b1);
        @(posedge clk);
        #1;
        s8 = 1'b0;
        wait_done(12, k);
        chk("b2b first lat", k, 8);
        chk("b2b first diff", diff8, 'h0C);
        @(negedge clk);
        drive(8, 'h04, 'h10, 0, 1'b1);
        @(posedge clk);
        #1;
        s8 = 1'b0;
        chk("b2b no gap busy", busy8, 1);
        chk("b2b no gap done", done8, 0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b hold diff %0d", i), diff8, 'h0C);
            chk($sformatf("b2b hold busy %0d", i), busy8, 1);
        end
        @(posedge clk);
        #1;
        chk("b2b second done", done8, 1);
        chk("b2b second diff", diff8, 'hF4);
        chk("b2b second bout", bout8, 1);
        repeat (20) run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        for (int v = 0; v < 128; v++) run_op(3, v[6:4], v[3:1], int'(v[0]));
        for (int v = 0; v < 8; v++) run_op(1, int'(v[2]), int'(v[1]), int'(v[0]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
